// File: rtl/udc_pkg.sv
// udc_pkg: shared types and constants for the updown_counter_p slice.
//   state_t     : counter FSM states
//   mode_t      : CTRL[2:1] count modes
//   ADDR_*      : {a1,a0} register map
//   CTRL_*      : CTRL bit positions
//   STAT_*      : STATUS bit positions
package udc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ONESHOT = 2'd0,
    RELOAD  = 2'd1,
    FREERUN = 2'd2,
    RSVD    = 2'd3
  } mode_t;

  localparam logic [1:0] ADDR_LOAD   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_LIMIT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_DIR     = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_PAUSE   = 3;
  localparam int CTRL_BITS    = 4;

  localparam int STAT_ERR  = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_DONE = 2;

  // A start is only honoured in one of the three defined modes.
  function automatic logic mode_is_valid(mode_t m);
    return (m != RSVD);
  endfunction

endpackage

// File: rtl/udc_regif.sv
// udc_regif: bus decode, LOAD/CTRL/LIMIT registers, registered readback
// and the sticky error flag.
//   clk, reset        : clock, async active-high reset
//   din, ncs/nrd/nwr  : CPU bus (active-low strobes), a1/a0 address
//   busy, done        : FSM status for STATUS readback
//   start_err         : one-cycle request from the FSM to set err
//   dout, err         : registered read data, sticky error flag
//   load, limit       : current LOAD / LIMIT register values
//   limit_nxt         : LIMIT value after this edge
//   dir_cfg, mode_cfg : CTRL direction and mode fields
//   pause, pause_nxt  : CTRL pause now / after this edge
module udc_regif
  import udc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             ncs,
  input  logic             nrd,
  input  logic             nwr,
  input  logic             a0,
  input  logic             a1,
  input  logic             busy,
  input  logic             done,
  input  logic             start_err,
  output logic [WIDTH-1:0] dout,
  output logic             err,
  output logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] limit_nxt,
  output logic             dir_cfg,
  output logic [1:0]       mode_cfg,
  output logic             pause,
  output logic             pause_nxt
);

  // Internal width wide enough for both the bus and the 4-bit CTRL field.
  localparam int XW = (WIDTH > CTRL_BITS) ? WIDTH : CTRL_BITS;
  localparam logic [XW-1:0] CTRL_MASK = XW'(4'hF);

  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [XW-1:0]    ctrl_q, ctrl_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             err_q, err_d;
  logic [XW-1:0]    rd_x;
  logic [1:0]       addr;
  logic             wr_en, rd_en, clash;

  assign addr  = {a1, a0};
  assign wr_en = ~ncs & ~nwr & nrd;
  assign rd_en = ~ncs & ~nrd & nwr;
  // Both strobes low is an illegal cycle: no access, flag it.
  assign clash = ~ncs & ~nrd & ~nwr;

  // Register writes, readback mux and err set/clear.
  always_comb begin
    load_d  = load_q;
    limit_d = limit_q;
    ctrl_d  = ctrl_q;
    dout_d  = dout_q;
    err_d   = err_q;
    rd_x    = '0;

    if (wr_en) begin
      case (addr)
        ADDR_LOAD:  load_d  = din;
        // Upper CTRL bits are never stored, so they always read back 0.
        ADDR_CTRL:  ctrl_d  = XW'(din) & CTRL_MASK;
        ADDR_LIMIT: limit_d = din;
        default:    load_d  = load_q;   // STATUS is read-only
      endcase
    end else begin
      load_d = load_q;
    end

    case (addr)
      ADDR_LOAD:  rd_x = XW'(load_q);
      ADDR_CTRL:  rd_x = ctrl_q;
      ADDR_LIMIT: rd_x = XW'(limit_q);
      default: begin
        rd_x[STAT_ERR]  = err_q;
        rd_x[STAT_BUSY] = busy;
        rd_x[STAT_DONE] = done;
      end
    endcase

    if (rd_en) begin
      dout_d = rd_x[WIDTH-1:0];
    end else begin
      dout_d = dout_q;
    end

    // dout captures the old err; a new error in the same edge wins over the clear.
    if (clash || start_err) begin
      err_d = 1'b1;
    end else if (rd_en && (addr == ADDR_STATUS)) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q  <= '0;
      limit_q <= RST_LIMIT;
      ctrl_q  <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      limit_q <= limit_d;
      ctrl_q  <= ctrl_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  assign dout      = dout_q;
  assign err       = err_q;
  assign load      = load_q;
  assign limit     = limit_q;
  assign limit_nxt = limit_d;
  assign dir_cfg   = ctrl_q[CTRL_DIR];
  assign mode_cfg  = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
  assign pause     = ctrl_q[CTRL_PAUSE];
  assign pause_nxt = ctrl_d[CTRL_PAUSE];

endmodule

// File: rtl/updown_counter_p.sv
// updown_counter_p: parametrised up/down counter with a CPU register interface.
//   clk, reset          : clock, async active-high reset
//   din, dout           : bus write data / registered read data
//   ncs, nrd, nwr       : active-low chip select, read and write strobes
//   a0, a1              : register address
//   start               : count request, rising edge detected
//   cout, dir, err, ec  : count value, active direction, sticky error, end-count pulse
module updown_counter_p
  import udc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             ncs,
  input  logic             nrd,
  input  logic             nwr,
  input  logic             a0,
  input  logic             a1,
  input  logic             start,
  output logic [WIDTH-1:0] cout,
  output logic             dir,
  output logic             err,
  output logic             ec
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d, mode_sel;
  logic [WIDTH-1:0] cout_q, cout_d, step;
  logic             dir_q, dir_d;
  logic             ec_q, ec_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] load, limit, limit_nxt;
  logic [1:0]       mode_cfg;
  logic             dir_cfg, pause, pause_nxt;
  logic             start_edge, can_try, range_bad, start_ok, start_err;

  udc_regif #(
    .WIDTH    (WIDTH),
    .RST_LIMIT(RST_LIMIT)
  ) u_regif (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .ncs      (ncs),
    .nrd      (nrd),
    .nwr      (nwr),
    .a0       (a0),
    .a1       (a1),
    .busy     (state_q == COUNT),
    .done     (state_q == DONE),
    .start_err(start_err),
    .dout     (dout),
    .err      (err),
    .load     (load),
    .limit    (limit),
    .limit_nxt(limit_nxt),
    .dir_cfg  (dir_cfg),
    .mode_cfg (mode_cfg),
    .pause    (pause),
    .pause_nxt(pause_nxt)
  );

  // Terminal value: LIMIT/0 normally, all-ones/0 in free-run.
  function automatic logic is_term(logic [WIDTH-1:0] cnt, logic [WIDTH-1:0] lim,
                                   logic up, mode_t m);
    logic [WIDTH-1:0] tgt;
    if (m == FREERUN) begin
      tgt = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end else begin
      tgt = up ? lim : {WIDTH{1'b0}};
    end
    return (cnt == tgt);
  endfunction

  assign mode_sel   = mode_t'(mode_cfg);
  assign start_edge = start & ~start_q;
  assign can_try    = start_edge & (state_q != COUNT);
  // Counting up from above LIMIT could never reach the terminal value.
  assign range_bad  = dir_cfg & (mode_sel != FREERUN) & (load > limit);
  assign start_ok   = can_try & mode_is_valid(mode_sel) & ~range_bad;
  assign start_err  = can_try & (~mode_is_valid(mode_sel) | range_bad);
  assign step       = dir_q ? (cout_q + WIDTH'(1'b1)) : (cout_q - WIDTH'(1'b1));

  // Next-state, count datapath and end-count look-ahead.
  always_comb begin
    state_d = state_q;
    cout_d  = cout_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    start_d = start;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = COUNT;
          cout_d  = load;
          dir_d   = dir_cfg;
          mode_d  = mode_sel;
        end else begin
          state_d = state_q;
        end
      end
      COUNT: begin
        if (pause) begin
          cout_d = cout_q;
        end else if (is_term(cout_q, limit, dir_q, mode_q)) begin
          case (mode_q)
            ONESHOT: state_d = DONE;
            RELOAD:  cout_d  = load;
            FREERUN: cout_d  = step;
            default: state_d = DONE;
          endcase
        end else begin
          cout_d = step;
        end
      end
      default: state_d = IDLE;
    endcase

    // ec is registered, so it is computed from the values the next cycle will
    // hold; it is then high exactly in the cycle that performs the terminal update.
    ec_d = (state_d == COUNT) && !pause_nxt && is_term(cout_d, limit_nxt, dir_d, mode_d);
  end

  // FSM and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= ONESHOT;
      cout_q  <= '0;
      dir_q   <= 1'b0;
      ec_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cout_q  <= cout_d;
      dir_q   <= dir_d;
      ec_q    <= ec_d;
      start_q <= start_d;
    end
  end

  assign cout = cout_q;
  assign dir  = dir_q;
  assign ec   = ec_q;

endmodule

// File: tb/tb_updown_counter_p.sv
// Testbench for updown_counter_p: one 8-bit and one 16-bit instance.
// Expectations are queued with the cycle they apply to; a monitor on the
// falling edge pops and compares them.
module tb_updown_counter_p;

  localparam logic [1:0] A_LOAD = 2'd0, A_CTRL = 2'd1, A_LIMIT = 2'd2, A_STAT = 2'd3;
  localparam int S_COUT = 0, S_EC = 1, S_ERR = 2, S_DIR = 3, S_DOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic [15:0] din   [2];
  logic        ncs   [2];
  logic        nrd   [2];
  logic        nwr   [2];
  logic        a0    [2];
  logic        a1    [2];
  logic        start [2];

  logic [7:0]  dout0, cout0;
  logic [15:0] dout1, cout1;
  logic        dir0, dir1, err0, err1, ec0, ec1;

  updown_counter_p #(.WIDTH(8)) dut0 (
    .clk(clk), .reset(rst[0]), .din(din[0][7:0]), .dout(dout0),
    .ncs(ncs[0]), .nrd(nrd[0]), .nwr(nwr[0]), .a0(a0[0]), .a1(a1[0]),
    .start(start[0]), .cout(cout0), .dir(dir0), .err(err0), .ec(ec0)
  );

  updown_counter_p #(.WIDTH(16)) dut1 (
    .clk(clk), .reset(rst[1]), .din(din[1]), .dout(dout1),
    .ncs(ncs[1]), .nrd(nrd[1]), .nwr(nwr[1]), .a0(a0[1]), .a1(a1[1]),
    .start(start[1]), .cout(cout1), .dir(dir1), .err(err1), .ec(ec1)
  );

  typedef struct {
    int          tag;
    int          d;
    int          sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_left = 0;
  logic [15:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(int d, int sig);
    case (sig)
      S_COUT:  return (d == 0) ? {8'h00, cout0} : cout1;
      S_EC:    return (d == 0) ? {15'd0, ec0}  : {15'd0, ec1};
      S_ERR:   return (d == 0) ? {15'd0, err0} : {15'd0, err1};
      S_DIR:   return (d == 0) ? {15'd0, dir0} : {15'd0, dir1};
      S_DOUT:  return (d == 0) ? {8'h00, dout0} : dout1;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tag <= cyc) begin
        n_chk = n_chk + 1;
        mon_act = actual(sb[i].d, sb[i].sig);
        if (sb[i].tag == cyc && mon_act === sb[i].exp) begin
          n_pass = n_pass + 1;
        end else begin
          $display("FAIL %s: dut%0d cycle %0d got %h expected %h (due cycle %0d)",
                   sb[i].name, sb[i].d, cyc, mon_act, sb[i].exp, sb[i].tag);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(int tag, int d, int sig, logic [15:0] v, string nm);
    exp_t e;
    e.tag = tag; e.d = d; e.sig = sig; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) tick();
  endtask

  task automatic bus_idle(int d);
    ncs[d] = 1'b1; nrd[d] = 1'b1; nwr[d] = 1'b1;
  endtask

  task automatic wr(int d, logic [1:0] ad, logic [15:0] v);
    ncs[d] = 1'b0; nwr[d] = 1'b0; nrd[d] = 1'b1;
    {a1[d], a0[d]} = ad;
    din[d] = v;
    tick();
    bus_idle(d);
  endtask

  task automatic rd(int d, logic [1:0] ad, logic [15:0] v, string nm);
    ncs[d] = 1'b0; nrd[d] = 1'b0; nwr[d] = 1'b1;
    {a1[d], a0[d]} = ad;
    expect_at(cyc + 1, d, S_DOUT, v, nm);
    tick();
    bus_idle(d);
  endtask

  task automatic clash(int d);
    ncs[d] = 1'b0; nrd[d] = 1'b0; nwr[d] = 1'b0;
    tick();
    bus_idle(d);
  endtask

  task automatic pulse_start(int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic do_reset(int d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
  endtask

  int          c;
  logic [15:0] v;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; din[d] = 16'h0000; start[d] = 1'b0;
      a0[d] = 1'b0; a1[d] = 1'b0;
      bus_idle(d);
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      expect_at(cyc, d, S_COUT, 16'h0000, "rst_cout");
      expect_at(cyc, d, S_EC,   16'h0000, "rst_ec");
      expect_at(cyc, d, S_ERR,  16'h0000, "rst_err");
      expect_at(cyc, d, S_DIR,  16'h0000, "rst_dir");
      expect_at(cyc, d, S_DOUT, 16'h0000, "rst_dout");
    end
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // Up one-shot 3..6, then DONE holding 6.
    wr(0, A_LOAD, 16'h0003); wr(0, A_LIMIT, 16'h0006); wr(0, A_CTRL, 16'h0001);
    c = cyc;
    for (int k = 1; k <= 6; k++) begin
      v = (k < 4) ? 16'(2 + k) : 16'h0006;
      expect_at(c + k, 0, S_COUT, v, "oneshot_cout");
      expect_at(c + k, 0, S_EC, (k == 4) ? 16'h0001 : 16'h0000, "oneshot_ec");
    end
    expect_at(c + 1, 0, S_DIR, 16'h0001, "oneshot_dir");
    pulse_start(0);
    wait_until(c + 6);
    expect_at(cyc + 1, 0, S_COUT, 16'h0006, "done_hold");
    rd(0, A_STAT, 16'h0004, "status_done");
    tick();

    // Down auto-reload 5..0 twice; a start during COUNT is ignored.
    wr(0, A_LOAD, 16'h0005); wr(0, A_CTRL, 16'h0002);
    c = cyc;
    for (int k = 1; k <= 13; k++) begin
      v = 16'(5 - ((k - 1) % 6));
      expect_at(c + k, 0, S_COUT, v, "reload_cout");
      expect_at(c + k, 0, S_EC, (v == 16'h0000) ? 16'h0001 : 16'h0000, "reload_ec");
    end
    expect_at(c + 1, 0, S_DIR, 16'h0000, "reload_dir");
    expect_at(c + 5, 0, S_ERR, 16'h0000, "reload_noerr");
    pulse_start(0);
    tick();
    pulse_start(0);
    rd(0, A_STAT, 16'h0002, "status_busy");
    wait_until(c + 14);
    do_reset(0);

    // Up free-run wrap FE,FF,00 then pause freezes.
    wr(0, A_LOAD, 16'h00FE); wr(0, A_CTRL, 16'h0005);
    c = cyc;
    for (int k = 1; k <= 9; k++) begin
      v = (k < 5) ? 16'((16'h00FD + k) & 16'h00FF) : 16'h0002;
      expect_at(c + k, 0, S_COUT, v, "free_cout");
      expect_at(c + k, 0, S_EC, (k == 2) ? 16'h0001 : 16'h0000, "free_ec");
    end
    pulse_start(0);
    wait_until(c + 4);
    wr(0, A_CTRL, 16'h000D);
    wait_until(c + 10);
    do_reset(0);

    // Error paths: LOAD>LIMIT, STATUS clear, strobe clash, reserved mode.
    wr(0, A_LOAD, 16'h0009); wr(0, A_LIMIT, 16'h0004); wr(0, A_CTRL, 16'h0001);
    c = cyc;
    expect_at(c + 1, 0, S_COUT, 16'h0000, "range_nostart");
    expect_at(c + 1, 0, S_ERR,  16'h0001, "range_err");
    expect_at(c + 2, 0, S_ERR,  16'h0000, "stat_clr");
    expect_at(c + 3, 0, S_ERR,  16'h0001, "clash_err");
    expect_at(c + 3, 0, S_DOUT, 16'h0001, "dout_hold");
    expect_at(c + 4, 0, S_ERR,  16'h0000, "stat_clr2");
    expect_at(c + 6, 0, S_ERR,  16'h0001, "rsvd_err");
    expect_at(c + 6, 0, S_COUT, 16'h0000, "rsvd_nostart");
    pulse_start(0);
    rd(0, A_STAT, 16'h0001, "status_err");
    clash(0);
    rd(0, A_STAT, 16'h0001, "status_err2");
    wr(0, A_CTRL, 16'h0006);
    pulse_start(0);
    rd(0, A_STAT, 16'h0001, "status_idle_err");
    tick();

    // Async reset mid-count at 0x40 clears immediately.
    clash(0);
    wr(0, A_LIMIT, 16'h0010); wr(0, A_LOAD, 16'h003E); wr(0, A_CTRL, 16'h0005);
    c = cyc;
    expect_at(c + 1, 0, S_COUT, 16'h003E, "pre_rst_cout");
    expect_at(c + 2, 0, S_COUT, 16'h003F, "pre_rst_cout");
    expect_at(c + 2, 0, S_ERR,  16'h0001, "pre_rst_err");
    pulse_start(0);
    tick(); tick();
    expect_at(cyc, 0, S_COUT, 16'h0000, "arst_cout");
    expect_at(cyc, 0, S_EC,   16'h0000, "arst_ec");
    expect_at(cyc, 0, S_ERR,  16'h0000, "arst_err");
    expect_at(cyc, 0, S_DIR,  16'h0000, "arst_dir");
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    rd(0, A_LIMIT, 16'h00FF, "arst_limit");
    rd(0, A_LOAD,  16'h0000, "arst_load");
    rd(0, A_CTRL,  16'h0000, "arst_ctrl");
    tick();

    // 16-bit instance: free-run wrap and register readback.
    wr(1, A_LOAD, 16'hFFFD); wr(1, A_CTRL, 16'h0005); wr(1, A_LIMIT, 16'h1234);
    c = cyc;
    for (int k = 1; k <= 5; k++) begin
      v = 16'hFFFC + 16'(k);
      expect_at(c + k, 1, S_COUT, v, "w16_cout");
      expect_at(c + k, 1, S_EC, (k == 3) ? 16'h0001 : 16'h0000, "w16_ec");
    end
    pulse_start(1);
    wait_until(c + 5);
    wr(1, A_CTRL, 16'h000D);
    rd(1, A_LOAD,  16'hFFFD, "w16_load");
    rd(1, A_CTRL,  16'h000D, "w16_ctrl");
    rd(1, A_LIMIT, 16'h1234, "w16_limit");
    wr(1, A_STAT,  16'hFFFF);
    rd(1, A_STAT,  16'h0002, "w16_status");
    tick(); tick();

    n_left = sb.size();
    if (n_left != 0) begin
      $display("FAIL leftover: %0d expectations never compared, required 0", n_left);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk + n_left);
    $finish;
  end

endmodule

// File: doc/updown_counter_p.md
Name: updown_counter_p

Overview:
Parametrised up/down counter with a CPU-style register interface (active-low chip-select/read/write, 2-bit address). It replaces the fixed 8-bit counter with configurable width, a programmable upper limit, three count modes, pause, and a registered readback path. It sits on the local bus as a memory-mapped timer/event counter; `cout`, `dir`, `err` and `ec` drive downstream logic directly.

Parameters:
WIDTH, 8, counter, register and bus data width (≥2)
RST_LIMIT, {WIDTH{1'b1}}, LIMIT register value after reset

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
din  input  WIDTH  write data
dout  output  WIDTH  registered read data
ncs  input  1  chip select, active low
nrd  input  1  read strobe, active low
nwr  input  1  write strobe, active low
a0  input  1  address bit 0
a1  input  1  address bit 1
start  input  1  count start request, rising-edge detected
cout  output  WIDTH  current count
dir  output  1  active direction: 1=up, 0=down
err  output  1  sticky error flag
ec  output  1  end-count pulse, one cycle

Behaviour:
- Reset (async): all outputs 0; LOAD=0, CTRL=0, LIMIT=RST_LIMIT; state IDLE; start edge detector cleared.
- Register map {a1,a0}:
  - 0 LOAD (R/W)
  - 1 CTRL (R/W): [0]=dir, [2:1]=mode, [3]=pause, upper bits read 0
  - 2 LIMIT (R/W)
  - 3 STATUS (R): [0]=err, [1]=busy (state==COUNT), [2]=done
- Write: on any edge with ncs=0, nwr=0, nrd=1, `din` is captured into the addressed register. Write to STATUS is ignored.
- Read: with ncs=0, nrd=0, nwr=1, `dout` takes the addressed value at the next edge (1-cycle latency). `dout` holds otherwise. A STATUS read clears `err` in that same edge, after `dout` has captured err=1.
- ncs=0 with nrd=0 and nwr=0 together: no access, err<=1.
- Modes:
  - 00 one-shot
  - 01 auto-reload
  - 10 free-run
  - 11 reserved: a start in this mode sets err<=1 and does not start.
- States:
  - IDLE: rising edge of start with a valid mode → COUNT; cout<=LOAD and dir<=CTRL[0] latched at that edge.
  - COUNT: each cycle with pause=0, cout ±1 per the latched dir. pause=1 holds cout; ec is not generated while paused.
  - DONE: cout holds. A start edge → COUNT (reload as from IDLE).
- Terminal condition:
  - Up: cout==LIMIT.
  - Down: cout==0.
  - Free-run ignores LIMIT: terminal is up at all-ones (next 0), down at 0 (next all-ones).
- At terminal, ec=1 for exactly one cycle, in the cycle cout is updated per mode:
  - one-shot: cout stays at terminal value → DONE.
  - auto-reload: cout<=LOAD, stay COUNT.
  - free-run: modulo-2^WIDTH wrap, stay COUNT.
- Up count with LOAD>LIMIT (non-free-run) at start: err<=1, no start, stays IDLE/DONE.
- Writes during COUNT:
  - LOAD and LIMIT writes take effect at the next reload or compare.
  - A CTRL write changes pause immediately.
  - dir/mode changes apply only at the next start.
- A start edge while in COUNT is ignored.
- Simultaneous terminal and STATUS read: both proceed.
- ec is combinationally independent of the bus.
- `err` is only set, never cleared, by count logic.
- Arithmetic is unsigned WIDTH-bit; no carry output.

Decomposition:
- Shared package `udc_pkg`:
  - typedef enum state_t {IDLE, COUNT, DONE}
  - typedef enum mode_t {ONESHOT, RELOAD, FREERUN, RSVD}
  - address localparams ADDR_LOAD/CTRL/LIMIT/STATUS
  - CTRL bit-index localparams
- One natural sub-module: `udc_regif` (bus decode, registers, readback, err set/clear). The top holds the FSM and counter datapath.

Test Plan:
- WIDTH=8: LOAD=3, CTRL=0x01 (up, one-shot), LIMIT=6, pulse start → cout 3,4,5,6 on successive cycles; ec=1 only in the cycle cout becomes 6; STATUS read shows done=1; cout holds 6.
- LOAD=5, CTRL=0x02 (down, reload) → cout 5..0, then 5 again; ec once per pass; busy stays 1.
- CTRL=0x05 (up, free-run), LOAD=0xFE → cout FE,FF,00 with ec at FF→00; then set pause=1 → cout frozen, no ec.
- Error paths:
  - LOAD=9, LIMIT=4, up one-shot, start → stays IDLE, err=1.
  - STATUS read → dout[0]=1, then err=0.
  - Then nrd=nwr=0 with ncs=0 → err=1.
- Assert reset mid-count at cout=0x40 → same-cycle async clear: cout=0, ec=0, err=0, LIMIT=RST_LIMIT.
- Rerun at WIDTH=16: LOAD=0xFFFD, up free-run → wraps to 0x0000 with one ec; readback of each register matches the last write.
